// File: rtl/hcsr04_pkg.sv
// hcsr04_pkg: shared FSM states, default timing and width helpers for the HC-SR04 echo emulator
package hcsr04_pkg;

    typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO, HOLDOFF} state_t;

    localparam int TRIG_MIN_CYCLES_DEF = 1000;
    localparam int BURST_CYCLES_DEF    = 20000;
    localparam int CYCLES_PER_CM_DEF   = 5800;
    localparam int MIN_CM_DEF          = 2;
    localparam int MAX_CM_DEF          = 400;
    localparam int TIMEOUT_CYCLES_DEF  = 3800000;
    localparam int HOLDOFF_CYCLES_DEF  = 1000000;

    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

    function automatic int echo_len_width(input int timeout_cycles, input int max_cm, input int cycles_per_cm);
        return $clog2(max2(timeout_cycles, max_cm * cycles_per_cm) + 1);
    endfunction

endpackage

// File: rtl/hcsr04_echo_emulator_trig_sync.sv
// trig_sync: two-flop Trig synchronizer with registered rise/fall pulses
module trig_sync (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic rise,
    output logic fall
);

    logic       s1, s2, s3;
    logic [1:0] fill;
    logic       armed;

    // Rises stay blocked until a real low is seen once the synchronizer holds valid samples,
    // so a Trig held high across reset cannot start a measurement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            fill  <= 2'b00;
            armed <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1    <= trig;
            s2    <= s1;
            s3    <= s2;
            fill  <= {fill[0], 1'b1};
            armed <= armed | (fill[1] & ~s2);
            rise  <= s2 & ~s3 & armed;
            fall  <= ~s2 & s3;
        end
    end

endmodule

// File: rtl/hcsr04_echo_emulator.sv
// hcsr04_echo_emulator: sensor-side HC-SR04 model returning an Echo pulse whose width encodes distance
module hcsr04_echo_emulator
    import hcsr04_pkg::*;
#(
    parameter int TRIG_MIN_CYCLES = TRIG_MIN_CYCLES_DEF,
    parameter int BURST_CYCLES    = BURST_CYCLES_DEF,
    parameter int CYCLES_PER_CM   = CYCLES_PER_CM_DEF,
    parameter int MIN_CM          = MIN_CM_DEF,
    parameter int MAX_CM          = MAX_CM_DEF,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
    parameter int HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Trig,
    input  logic [8:0] distance_cm,
    input  logic       obj_present,
    output logic       Echo,
    output logic       busy,
    output logic       trig_err,
    output logic       echo_done
);

    localparam int LEN_W = echo_len_width(TIMEOUT_CYCLES, MAX_CM, CYCLES_PER_CM);
    localparam int CNT_W = max2(LEN_W, $clog2(max2(max2(TRIG_MIN_CYCLES, BURST_CYCLES), HOLDOFF_CYCLES) + 1));
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TRIG_MIN = CNT_W'(TRIG_MIN_CYCLES);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [LEN_W-1:0] len, len_nx, len_calc;
    logic             rise, fall, err_nx;

    trig_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .trig (Trig),
        .rise (rise),
        .fall (fall)
    );

    // Echo length for the current inputs: timeout for no object, clamp short distances up
    always_comb begin
        len_calc = (!obj_present || int'(distance_cm) > MAX_CM) ? LEN_W'(TIMEOUT_CYCLES)
                 : (int'(distance_cm) < MIN_CM) ? LEN_W'(MIN_CM * CYCLES_PER_CM)
                 : LEN_W'(int'(distance_cm) * CYCLES_PER_CM);
    end

    // Next state; the shared counter counts Trig width up in TRIG_HI and phase length down elsewhere
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        len_nx   = len;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = TRIG_HI;
                    cnt_nx   = ONE;
                end
            end
            TRIG_HI: begin
                if (fall) begin
                    if (cnt < TRIG_MIN) begin
                        state_nx = IDLE;
                        err_nx   = 1'b1;
                    end else begin
                        state_nx = BURST;
                        len_nx   = len_calc;
                        cnt_nx   = CNT_W'(BURST_CYCLES - 1);
                    end
                end else if (cnt < TRIG_MIN) begin
                    cnt_nx = cnt + ONE;
                end
            end
            BURST: begin
                if (cnt == '0) begin
                    state_nx = ECHO;
                    cnt_nx   = CNT_W'(len) - ONE;
                end else begin
                    cnt_nx = cnt - ONE;
                end
            end
            ECHO: begin
                if (cnt == '0) begin
                    state_nx = HOLDOFF;
                    cnt_nx   = CNT_W'(HOLDOFF_CYCLES - 1);
                end else begin
                    cnt_nx = cnt - ONE;
                end
            end
            HOLDOFF: begin
                if (cnt == '0) state_nx = IDLE;
                else cnt_nx = cnt - ONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, counter, latched length and registered outputs derived from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            len       <= '0;
            Echo      <= 1'b0;
            busy      <= 1'b0;
            trig_err  <= 1'b0;
            echo_done <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            len       <= len_nx;
            Echo      <= state_nx == ECHO;
            busy      <= state_nx != IDLE;
            trig_err  <= err_nx;
            echo_done <= state == ECHO && state_nx == HOLDOFF;
        end
    end

endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// tb_hcsr04_echo_emulator: scoreboard bench for the HC-SR04 echo emulator
module tb_hcsr04_echo_emulator;

    localparam int TRIG_MIN = 10;
    localparam int BURST    = 20;
    localparam int CPC      = 5;
    localparam int MIN_CM   = 2;
    localparam int MAX_CM   = 400;
    localparam int TIMEOUT  = 3000;
    localparam int HOLDOFF  = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Trig = 1'b0;
    logic [8:0] distance_cm = 9'd100;
    logic       obj_present = 1'b1;
    logic       Echo, busy, trig_err, echo_done;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit is_err;
        int at;
        int width;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   rise_at = 0;
    bit   in_pulse = 1'b0;
    bit   prev_err = 1'b0;

    hcsr04_echo_emulator #(
        .TRIG_MIN_CYCLES (TRIG_MIN),
        .BURST_CYCLES    (BURST),
        .CYCLES_PER_CM   (CPC),
        .MIN_CM          (MIN_CM),
        .MAX_CM          (MAX_CM),
        .TIMEOUT_CYCLES  (TIMEOUT),
        .HOLDOFF_CYCLES  (HOLDOFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Trig        (Trig),
        .distance_cm (distance_cm),
        .obj_present (obj_present),
        .Echo        (Echo),
        .busy        (busy),
        .trig_err    (trig_err),
        .echo_done   (echo_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: measures each Echo pulse and trig_err pulse and matches it against the queue
    always @(negedge clk) begin
        if (rst) begin
            in_pulse = 1'b0;
            prev_err = 1'b0;
        end else begin
            if (Echo && !in_pulse) begin
                in_pulse = 1'b1;
                rise_at  = cyc;
            end else if (!Echo && in_pulse) begin
                in_pulse = 1'b0;
                check("echo_done_on_fall", echo_done, 1);
                if (exp_q.size() == 0) begin
                    check("echo_expected", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("echo_kind", mon_e.is_err, 0);
                    check("echo_rise_cycle", rise_at, mon_e.at);
                    check("echo_width", cyc - rise_at, mon_e.width);
                end
            end else if (echo_done) begin
                check("echo_done_spurious", echo_done, 0);
            end
            if (trig_err) begin
                if (prev_err) begin
                    check("trig_err_single", prev_err, 0);
                end else if (exp_q.size() == 0) begin
                    check("trig_err_expected", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("err_kind", mon_e.is_err, 1);
                    check("err_cycle", cyc, mon_e.at);
                end
            end
            prev_err = trig_err;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic trig_pulse(input int n);
        Trig = 1'b1;
        tick(n);
        Trig = 1'b0;
    endtask

    task automatic measure(input int n, input int width);
        trig_pulse(n);
        exp_q.push_back('{1'b0, cyc + BURST + 4, width});
    endtask

    task automatic wait_idle(input string name, input int bound);
        int k = 0;
        while (busy !== 1'b0 && k < bound) begin
            tick(1);
            k++;
        end
        check(name, busy, 0);
    endtask

    task automatic wait_echo(input string name, input int bound);
        int k = 0;
        while (Echo !== 1'b1 && k < bound) begin
            tick(1);
            k++;
        end
        check(name, Echo, 1);
    endtask

    initial begin
        tick(3);
        check("rst_echo", Echo, 0);
        check("rst_busy", busy, 0);
        check("rst_trig_err", trig_err, 0);
        check("rst_echo_done", echo_done, 0);
        rst = 1'b0;
        tick(5);

        distance_cm = 9'd100;
        measure(12, 500);
        tick(BURST + 9);
        check("t1_busy_in_echo", busy, 1);
        check("t1_echo_high", Echo, 1);
        wait_idle("t1_idle", 5000);

        trig_pulse(5);
        exp_q.push_back('{1'b1, cyc + 4, 0});
        wait_idle("t2_idle", 100);
        tick(5);
        check("t2_echo_low", Echo, 0);
        check("t2_busy_low", busy, 0);

        obj_present = 1'b0;
        measure(12, TIMEOUT);
        wait_idle("t3_noobj_idle", 5000);
        obj_present = 1'b1;
        distance_cm = 9'd401;
        measure(12, TIMEOUT);
        wait_idle("t3_far_idle", 5000);
        distance_cm = 9'd400;
        measure(12, 400 * CPC);
        wait_idle("t3_max_idle", 5000);
        distance_cm = 9'd0;
        measure(12, MIN_CM * CPC);
        wait_idle("t3_zero_idle", 5000);
        distance_cm = 9'd1;
        measure(10, MIN_CM * CPC);
        wait_idle("t3_one_idle", 5000);
        distance_cm = 9'd2;
        measure(12, MIN_CM * CPC);
        wait_idle("t3_two_idle", 5000);

        distance_cm = 9'd100;
        measure(12, 500);
        tick(5);
        trig_pulse(3);
        tick(20);
        distance_cm = 9'd7;
        trig_pulse(12);
        tick(500);
        trig_pulse(12);
        wait_idle("t4_idle", 5000);
        tick(20);
        check("t4_no_restart", busy, 0);
        distance_cm = 9'd100;

        trig_pulse(12);
        wait_echo("t5_echo_rose", 100);
        tick(50);
        Trig = 1'b1;
        tick(3);
        rst = 1'b1;
        #1;
        check("t5_echo_async_reset", Echo, 0);
        check("t5_busy_async_reset", busy, 0);
        tick(3);
        rst = 1'b0;
        tick(40);
        check("t5_held_trig_ignored", busy, 0);
        Trig = 1'b0;
        tick(10);
        check("t5_fall_ignored", busy, 0);
        measure(12, 500);
        wait_idle("t5_idle", 5000);

        measure(12, 500);
        tick(BURST + 4 + 500 + 10);
        Trig = 1'b1;
        wait_idle("t6_holdoff_end", 500);
        tick(30);
        check("t6_held_no_measure", busy, 0);
        Trig = 1'b0;
        tick(10);
        check("t6_fall_no_measure", busy, 0);
        measure(12, 500);
        wait_idle("t6_idle", 5000);

        tick(5);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
